// File: rtl/unpack.sv
// Splits one W*D-bit input beat into D W-bit output words, least-significant word first.
// Latency: first word valid one cycle after the input transfer; then one word per accepted cycle.
// Backpressure: s_rdy only when empty or the last word leaves this cycle; m_* hold while m_rdy=0.
//
// Ports:
//   clk, rst      - clock and asynchronous active-low reset
//   s_stb/s_dat   - upstream offer of a packed beat; s_rdy accepts it
//   m_stb/m_dat   - current output word; m_lst marks the final word of a beat
//   m_rdy         - downstream accepts m_dat
module unpack #(
    parameter int W = 8,
    parameter int D = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_stb,
    input  logic [W*D-1:0] s_dat,
    output logic           s_rdy,
    output logic           m_stb,
    output logic [W-1:0]   m_dat,
    output logic           m_lst,
    input  logic           m_rdy
);

    localparam int CW = $clog2(D + 1);

    logic [W*D-1:0] r_buf;
    logic [CW-1:0]  r_cnt;   // words of the current beat not yet emitted
    logic           r_stb;   // registered copy of (r_cnt != 0)
    logic           r_lst;   // registered copy of (r_cnt == 1)

    logic w_in_xfer;
    logic w_out_xfer;

    // A new beat may enter in the same cycle the last word of the previous
    // one leaves, which keeps a sustained stream free of bubbles.
    assign s_rdy      = (r_cnt == '0) || (r_lst && m_rdy);
    assign w_in_xfer  = s_stb && s_rdy;
    assign w_out_xfer = r_stb && m_rdy;

    assign m_stb = r_stb;
    assign m_dat = r_buf[W-1:0];
    assign m_lst = r_lst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf <= '0;
            r_cnt <= '0;
            r_stb <= 1'b0;
            r_lst <= 1'b0;
        end else if (w_in_xfer) begin
            // D is at least 2, so a freshly loaded beat is never on its last word.
            r_buf <= s_dat;
            r_cnt <= CW'(D);
            r_stb <= 1'b1;
            r_lst <= 1'b0;
        end else if (w_out_xfer) begin
            r_buf <= r_buf >> W;
            r_cnt <= r_cnt - 1'b1;
            r_stb <= (r_cnt != CW'(1));
            r_lst <= (r_cnt == CW'(2));
        end
    end

endmodule

// File: tb/tb_unpack.sv
// Bench for unpack: directed scenarios on W=8/D=2 and W=4/D=3 instances,
// then randomized handshakes checked against a word-queue reference model.
module tb_unpack;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: W=8, D=2
    logic        a_s_stb, a_s_rdy, a_m_stb, a_m_lst, a_m_rdy;
    logic [15:0] a_s_dat;
    logic [7:0]  a_m_dat;
    // Instance B: W=4, D=3
    logic        b_s_stb, b_s_rdy, b_m_stb, b_m_lst, b_m_rdy;
    logic [11:0] b_s_dat;
    logic [3:0]  b_m_dat;

    unpack #(.W(8), .D(2)) dut_a (
        .clk(clk), .rst(rst),
        .s_stb(a_s_stb), .s_dat(a_s_dat), .s_rdy(a_s_rdy),
        .m_stb(a_m_stb), .m_dat(a_m_dat), .m_lst(a_m_lst), .m_rdy(a_m_rdy)
    );

    unpack #(.W(4), .D(3)) dut_b (
        .clk(clk), .rst(rst),
        .s_stb(b_s_stb), .s_dat(b_s_dat), .s_rdy(b_s_rdy),
        .m_stb(b_m_stb), .m_dat(b_m_dat), .m_lst(b_m_lst), .m_rdy(b_m_rdy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        a_s_stb = 1'b0; a_s_dat = '0; a_m_rdy = 1'b0;
        b_s_stb = 1'b0; b_s_dat = '0; b_m_rdy = 1'b0;
        #1;
        checks++; if (a_m_stb !== 1'b0) begin failures++; $display("FAIL reset_a_m_stb got=%0b exp=0", a_m_stb); end
        checks++; if (a_m_lst !== 1'b0) begin failures++; $display("FAIL reset_a_m_lst got=%0b exp=0", a_m_lst); end
        checks++; if (a_m_dat !== 8'h00) begin failures++; $display("FAIL reset_a_m_dat got=%h exp=00", a_m_dat); end
        checks++; if (a_s_rdy !== 1'b1) begin failures++; $display("FAIL reset_a_s_rdy got=%0b exp=1", a_s_rdy); end
        checks++; if (b_m_stb !== 1'b0) begin failures++; $display("FAIL reset_b_m_stb got=%0b exp=0", b_m_stb); end
        checks++; if (b_s_rdy !== 1'b1) begin failures++; $display("FAIL reset_b_s_rdy got=%0b exp=1", b_s_rdy); end
        // An offered beat during reset must not be captured.
        a_s_stb = 1'b1; a_s_dat = 16'h1357;
        tick();
        checks++; if (a_m_stb !== 1'b0) begin failures++; $display("FAIL reset_hold_m_stb got=%0b exp=0", a_m_stb); end
        @(negedge clk);
        a_s_stb = 1'b0;
        rst = 1'b1;
    endtask

    // 0xBEEF -> EF then BE, starting one cycle after the input transfer
    task automatic test_basic;
        logic [7:0] ew[2];
        ew[0] = 8'hEF; ew[1] = 8'hBE;
        tick();
        a_m_rdy = 1'b1; a_s_stb = 1'b1; a_s_dat = 16'hBEEF;
        @(negedge clk);
        checks++; if (a_s_rdy !== 1'b1) begin failures++; $display("FAIL basic_s_rdy got=%0b exp=1", a_s_rdy); end
        tick();
        a_s_stb = 1'b0; a_s_dat = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (a_m_stb !== 1'b1) begin failures++; $display("FAIL basic_m_stb w%0d got=%0b exp=1", k, a_m_stb); end
            checks++; if (a_m_dat !== ew[k]) begin failures++; $display("FAIL basic_m_dat w%0d got=%h exp=%h", k, a_m_dat, ew[k]); end
            checks++; if (a_m_lst !== (k == 1)) begin failures++; $display("FAIL basic_m_lst w%0d got=%0b exp=%0b", k, a_m_lst, (k == 1)); end
            tick();
        end
        @(negedge clk);
        checks++; if (a_m_stb !== 1'b0) begin failures++; $display("FAIL basic_idle_m_stb got=%0b exp=0", a_m_stb); end
    endtask

    // 0x1234, 0x5678 streamed -> 34,12,78,56 on consecutive cycles
    task automatic test_back_to_back;
        logic [7:0] ew[4];
        ew[0] = 8'h34; ew[1] = 8'h12; ew[2] = 8'h78; ew[3] = 8'h56;
        tick();
        a_m_rdy = 1'b1; a_s_stb = 1'b1; a_s_dat = 16'h1234;
        tick();
        a_s_dat = 16'h5678;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (a_m_stb !== 1'b1) begin failures++; $display("FAIL b2b_m_stb w%0d got=%0b exp=1", k, a_m_stb); end
            checks++; if (a_m_dat !== ew[k]) begin failures++; $display("FAIL b2b_m_dat w%0d got=%h exp=%h", k, a_m_dat, ew[k]); end
            checks++; if (a_m_lst !== k[0]) begin failures++; $display("FAIL b2b_m_lst w%0d got=%0b exp=%0b", k, a_m_lst, k[0]); end
            if (k[0]) begin
                checks++; if (a_s_rdy !== 1'b1) begin failures++; $display("FAIL b2b_s_rdy w%0d got=%0b exp=1", k, a_s_rdy); end
            end
            tick();
            if (k == 1) a_s_stb = 1'b0;
        end
        @(negedge clk);
        checks++; if (a_m_stb !== 1'b0) begin failures++; $display("FAIL b2b_idle_m_stb got=%0b exp=0", a_m_stb); end
    endtask

    // 0xA55A with m_rdy low for 5 cycles: 5A held, s_rdy low
    task automatic test_backpressure;
        tick();
        a_m_rdy = 1'b0; a_s_stb = 1'b1; a_s_dat = 16'hA55A;
        tick();
        a_s_stb = 1'b0; a_s_dat = 16'hFFFF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (a_m_stb !== 1'b1 || a_m_dat !== 8'h5A || a_m_lst !== 1'b0)
                begin failures++; $display("FAIL bp_hold c%0d got stb=%0b dat=%h lst=%0b exp stb=1 dat=5a lst=0", c, a_m_stb, a_m_dat, a_m_lst); end
            checks++; if (a_s_rdy !== 1'b0) begin failures++; $display("FAIL bp_s_rdy c%0d got=%0b exp=0", c, a_s_rdy); end
            tick();
        end
        a_m_rdy = 1'b1;
        @(negedge clk);
        checks++; if (a_m_dat !== 8'h5A) begin failures++; $display("FAIL bp_w0 got=%h exp=5a", a_m_dat); end
        tick();
        @(negedge clk);
        checks++; if (a_m_dat !== 8'hA5 || a_m_lst !== 1'b1) begin failures++; $display("FAIL bp_w1 got dat=%h lst=%0b exp dat=a5 lst=1", a_m_dat, a_m_lst); end
        tick();
        @(negedge clk);
        checks++; if (a_m_stb !== 1'b0) begin failures++; $display("FAIL bp_idle_m_stb got=%0b exp=0", a_m_stb); end
    endtask

    // 0xCAFE, FE taken, async reset mid-cycle -> CA never appears
    task automatic test_reset_mid;
        tick();
        a_m_rdy = 1'b1; a_s_stb = 1'b1; a_s_dat = 16'hCAFE;
        tick();
        a_s_stb = 1'b0;
        @(negedge clk);
        checks++; if (a_m_dat !== 8'hFE) begin failures++; $display("FAIL rmid_w0 got=%h exp=fe", a_m_dat); end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (a_m_stb !== 1'b0) begin failures++; $display("FAIL rmid_m_stb got=%0b exp=0", a_m_stb); end
        checks++; if (a_m_dat !== 8'h00) begin failures++; $display("FAIL rmid_m_dat got=%h exp=00", a_m_dat); end
        checks++; if (a_s_rdy !== 1'b1) begin failures++; $display("FAIL rmid_s_rdy got=%0b exp=1", a_s_rdy); end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            checks++; if (a_m_stb !== 1'b0) begin failures++; $display("FAIL rmid_after c%0d m_stb got=%0b exp=0 dat=%h", c, a_m_stb, a_m_dat); end
        end
        tick();
        a_s_stb = 1'b1; a_s_dat = 16'h3C96;
        tick();
        a_s_stb = 1'b0;
        @(negedge clk);
        checks++; if (a_m_dat !== 8'h96 || a_m_stb !== 1'b1) begin failures++; $display("FAIL rmid_fresh_w0 got dat=%h stb=%0b exp dat=96 stb=1", a_m_dat, a_m_stb); end
        tick();
        @(negedge clk);
        checks++; if (a_m_dat !== 8'h3C || a_m_lst !== 1'b1) begin failures++; $display("FAIL rmid_fresh_w1 got dat=%h lst=%0b exp dat=3c lst=1", a_m_dat, a_m_lst); end
    endtask

    // W=4 D=3: 0xABC -> C, B, A with m_lst only on A
    task automatic test_w4d3;
        logic [3:0] ew[3];
        ew[0] = 4'hC; ew[1] = 4'hB; ew[2] = 4'hA;
        tick();
        b_m_rdy = 1'b1; b_s_stb = 1'b1; b_s_dat = 12'hABC;
        tick();
        b_s_stb = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (b_m_stb !== 1'b1 || b_m_dat !== ew[k]) begin failures++; $display("FAIL w4_dat w%0d got stb=%0b dat=%h exp stb=1 dat=%h", k, b_m_stb, b_m_dat, ew[k]); end
            checks++; if (b_m_lst !== (k == 2)) begin failures++; $display("FAIL w4_lst w%0d got=%0b exp=%0b", k, b_m_lst, (k == 2)); end
            tick();
        end
        @(negedge clk);
        checks++; if (b_m_stb !== 1'b0) begin failures++; $display("FAIL w4_idle_m_stb got=%0b exp=0", b_m_stb); end
        b_m_rdy = 1'b0;
    endtask

    // Random stb/rdy; reference is a queue of words split from each accepted beat.
    task automatic test_random(input int which, input int beats);
        int        w, d, sent, cyc, budget, fails_here;
        int        q_w[$];
        bit        q_l[$];
        bit        stb, rdy, ms, ml, sr, hold, exp_sr;
        int        md, prev_md;
        bit        prev_ml;
        bit [31:0] beat;
        w = (which != 0) ? 4 : 8;
        d = (which != 0) ? 3 : 2;
        sent = 0; cyc = 0; hold = 1'b0; prev_md = 0; prev_ml = 1'b0; fails_here = 0;
        budget = beats * d * 8 + 200;
        while (sent < beats || q_w.size() != 0) begin
            tick();
            stb  = (sent < beats) && ($urandom_range(3) != 0);
            rdy  = ($urandom_range(3) != 0);
            beat = $urandom & ((32'd1 << (w * d)) - 1);
            if (which != 0) begin b_s_stb = stb; b_s_dat = beat[11:0]; b_m_rdy = rdy; end
            else            begin a_s_stb = stb; a_s_dat = beat[15:0]; a_m_rdy = rdy; end
            @(negedge clk);
            ms = (which != 0) ? b_m_stb : a_m_stb;
            ml = (which != 0) ? b_m_lst : a_m_lst;
            sr = (which != 0) ? b_s_rdy : a_s_rdy;
            md = (which != 0) ? int'(b_m_dat) : int'(a_m_dat);
            checks++;
            if (ms !== (q_w.size() != 0)) begin failures++; fails_here++; $display("FAIL rnd%0d_m_stb cyc=%0d got=%0b exp=%0b", which, cyc, ms, (q_w.size() != 0)); end
            if (ms && q_w.size() != 0) begin
                checks++;
                if (md != q_w[0] || ml != q_l[0]) begin failures++; fails_here++; $display("FAIL rnd%0d_word cyc=%0d got dat=%h lst=%0b exp dat=%h lst=%0b", which, cyc, md, ml, q_w[0], q_l[0]); end
            end
            if (hold) begin
                checks++;
                if (!ms || md != prev_md || ml != prev_ml) begin failures++; fails_here++; $display("FAIL rnd%0d_stable cyc=%0d got stb=%0b dat=%h lst=%0b exp stb=1 dat=%h lst=%0b", which, cyc, ms, md, ml, prev_md, prev_ml); end
            end
            exp_sr = (q_w.size() == 0) || (q_w.size() == 1 && rdy);
            checks++;
            if (sr !== exp_sr) begin failures++; fails_here++; $display("FAIL rnd%0d_s_rdy cyc=%0d got=%0b exp=%0b", which, cyc, sr, exp_sr); end
            hold = ms && !rdy; prev_md = md; prev_ml = ml;
            if (ms && rdy && q_w.size() != 0) begin void'(q_w.pop_front()); void'(q_l.pop_front()); end
            if (stb && sr) begin
                for (int k = 0; k < d; k++) begin
                    q_w.push_back(int'((beat >> (w * k)) & ((32'd1 << w) - 1)));
                    q_l.push_back(k == d - 1);
                end
                sent++;
            end
            cyc++;
            if (cyc > budget) begin
                failures++; $display("FAIL rnd%0d_timeout sent=%0d pending=%0d exp_pending=0", which, sent, q_w.size());
                break;
            end
            if (fails_here > 50) break;
        end
        tick();
        if (which != 0) begin b_s_stb = 1'b0; b_m_rdy = 1'b0; end
        else            begin a_s_stb = 1'b0; a_m_rdy = 1'b0; end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_w4d3();
        test_random(0, 10000);
        test_random(1, 2000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
